// File: rtl/bsg_dmc_pkg.sv
// Definitions shared by every block on the DMC user (app_*) interface.
// Command encoding matches the controller's app_cmd port.
package bsg_dmc_pkg;

  typedef enum logic [2:0] {
    WRITE = 3'b000,
    READ  = 3'b001
  } app_cmd_e;

endpackage

// File: rtl/bsg_dmc_ui_burst_master_pkg.sv
// Helpers shared by the burst master, its read buffer and its beat counters.
// Index widths never collapse to zero bits, even for single-entry configurations.
package bsg_dmc_ui_burst_master_pkg;

  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_dmc_ui_burst_master_if.sv
// DMC app_* command, write-data and read-data signals, named from the burst master's side.
// Read beats have no ready: the master sizes its read credit so it can always absorb them.
interface bsg_dmc_ui_burst_master_if #(
  parameter int addr_width_p = 28,
  parameter int data_width_p = 128
) ();

  logic [addr_width_p-1:0]   app_addr_o;
  bsg_dmc_pkg::app_cmd_e     app_cmd_o;
  logic                      app_en_o;
  logic                      app_rdy_i;

  logic                      app_wdf_wren_o;
  logic [data_width_p-1:0]   app_wdf_data_o;
  logic [data_width_p/8-1:0] app_wdf_mask_o;
  logic                      app_wdf_end_o;
  logic                      app_wdf_rdy_i;

  logic                      app_rd_data_valid_i;
  logic [data_width_p-1:0]   app_rd_data_i;
  logic                      app_rd_data_end_i;

  modport master (
    output app_addr_o, app_cmd_o, app_en_o,
    output app_wdf_wren_o, app_wdf_data_o, app_wdf_mask_o, app_wdf_end_o,
    input  app_rdy_i, app_wdf_rdy_i,
    input  app_rd_data_valid_i, app_rd_data_i, app_rd_data_end_i
  );

  modport slave (
    input  app_addr_o, app_cmd_o, app_en_o,
    input  app_wdf_wren_o, app_wdf_data_o, app_wdf_mask_o, app_wdf_end_o,
    output app_rdy_i, app_wdf_rdy_i,
    output app_rd_data_valid_i, app_rd_data_i, app_rd_data_end_i
  );

endinterface

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; count_o updates one cycle after clear_i/up_i.
// No backpressure: the caller decides when to count.
module bsg_counter_clear_up
  import bsg_dmc_ui_burst_master_pkg::*;
#(
  parameter  int max_val_p  = 1,
  parameter  int init_val_p = 0,
  localparam int width_lp   = safe_clog2(max_val_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clear_i,
  input  logic                up_i,
  output logic [width_lp-1:0] count_o
);

  logic [width_lp-1:0] count_q, count_d;

  // Clear and up together restart the count at one.
  always_comb begin
    count_d = clear_i ? '0 : count_q;
    if (up_i) count_d = count_d + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= width_lp'(init_val_p);
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/bsg_dmc_ui_burst_master_rbuf.sv
// Read-burst buffer: beats land at their beat index in the tail slot, a burst commits on its end beat.
// Head burst is visible the cycle after commit; yumi_i pops it; no input backpressure (credit upstream).
module bsg_dmc_ui_burst_master_rbuf
  import bsg_dmc_ui_burst_master_pkg::*;
#(
  parameter  int data_width_p = 128,
  parameter  int burst_len_p  = 2,
  parameter  int els_p        = 2,
  localparam int beat_w_lp    = safe_clog2(burst_len_p),
  localparam int ptr_w_lp     = safe_clog2(els_p),
  localparam int cnt_w_lp     = $clog2(els_p + 1)
) (
  input  logic                                clk_i,
  input  logic                                reset_i,

  input  logic                                beat_v_i,
  input  logic [data_width_p-1:0]             beat_data_i,
  input  logic                                beat_end_i,

  output logic [burst_len_p*data_width_p-1:0] data_o,
  input  logic                                yumi_i,

  output logic                                full_o,
  output logic                                empty_o,
  output logic [cnt_w_lp-1:0]                 count_o
);

  logic [burst_len_p-1:0][data_width_p-1:0] mem_q [els_p];

  logic [ptr_w_lp-1:0]  wptr_q, wptr_d;
  logic [ptr_w_lp-1:0]  rptr_q, rptr_d;
  logic [cnt_w_lp-1:0]  count_q, count_d;
  logic [beat_w_lp-1:0] beat_idx;
  logic                 commit;

  assign commit = beat_v_i & beat_end_i;

  bsg_counter_clear_up #(
    .max_val_p  (burst_len_p - 1),
    .init_val_p (0)
  ) beat_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (commit),
    .up_i    (beat_v_i & ~beat_end_i),
    .count_o (beat_idx)
  );

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wptr_d  = commit ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = yumi_i ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q + cnt_w_lp'(commit) - cnt_w_lp'(yumi_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (beat_v_i) mem_q[wptr_q][beat_idx] <= beat_data_i;
  end

  assign data_o  = mem_q[rptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == cnt_w_lp'(els_p));
  assign count_o = count_q;

  // An end beat must be the last beat of the burst; beats into a full buffer would clobber the head.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (beat_v_i) assert (beat_end_i == (beat_idx == beat_w_lp'(burst_len_p - 1)));
      assert (!(beat_v_i && full_o));
      assert (!(yumi_i && empty_o));
    end
  end

endmodule

// File: rtl/bsg_dmc_ui_burst_master.sv
// Burst front end for the DMC app_* port: app_en one cycle after accept, read bursts out on valid/yumi.
// ready_o drops while a burst is in flight, and for READs once outstanding+buffered reads fill the buffer.
module bsg_dmc_ui_burst_master
  import bsg_dmc_pkg::*;
  import bsg_dmc_ui_burst_master_pkg::*;
#(
  parameter int ui_addr_width_p = 28,
  parameter int ui_data_width_p = 128,
  parameter int ui_burst_len_p  = 2,
  parameter int rfifo_depth_p   = 2
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,

  input  logic                                      v_i,
  input  app_cmd_e                                  cmd_i,
  input  logic [ui_addr_width_p-1:0]                addr_i,
  input  logic [ui_burst_len_p*ui_data_width_p-1:0] data_i,
  input  logic [ui_burst_len_p*ui_data_width_p/8-1:0] mask_i,
  output logic                                      ready_o,

  output logic [ui_burst_len_p*ui_data_width_p-1:0] data_o,
  output logic                                      v_o,
  input  logic                                      yumi_i,

  bsg_dmc_ui_burst_master_if.master                 app_if
);

  localparam int mask_w_lp   = ui_data_width_p / 8;
  localparam int beat_w_lp   = safe_clog2(ui_burst_len_p);
  localparam int credit_w_lp = $clog2(rfifo_depth_p + 1);

  typedef enum logic [1:0] {eIdle, eWrite, eRead} state_e;

  state_e                                        state_q, state_d;
  app_cmd_e                                      cmd_q, cmd_d;
  logic [ui_addr_width_p-1:0]                    addr_q, addr_d;
  logic [ui_burst_len_p-1:0][ui_data_width_p-1:0] data_q, data_d;
  logic [ui_burst_len_p-1:0][mask_w_lp-1:0]      mask_q, mask_d;
  logic                                          cmd_done_q, cmd_done_d;
  logic                                          data_done_q, data_done_d;
  logic [credit_w_lp-1:0]                        credit_q, credit_d;

  logic [beat_w_lp-1:0]   wbeat;
  logic                   last_beat;
  logic                   read_hs, data_hs, last_hs;
  logic                   credit_avail;
  logic                   rbuf_full, rbuf_empty;
  logic [credit_w_lp-1:0] rbuf_count;

  assign last_beat = (wbeat == beat_w_lp'(ui_burst_len_p - 1));

  // A pop in the same cycle frees the slot a new READ would need.
  assign credit_avail = (credit_q < credit_w_lp'(rfifo_depth_p)) | yumi_i;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mask_d      = mask_q;
    cmd_done_d  = cmd_done_q;
    data_done_d = data_done_q;
    ready_o     = 1'b0;
    read_hs     = 1'b0;
    data_hs     = 1'b0;
    last_hs     = 1'b0;

    app_if.app_en_o       = 1'b0;
    app_if.app_wdf_wren_o = 1'b0;
    app_if.app_wdf_end_o  = 1'b0;

    unique case (state_q)
      eIdle: begin
        ready_o = ~reset_i & ((cmd_i == WRITE) | credit_avail);
        if (v_i & ready_o) begin
          cmd_d       = cmd_i;
          addr_d      = addr_i;
          data_d      = data_i;
          mask_d      = mask_i;
          cmd_done_d  = 1'b0;
          data_done_d = 1'b0;
          state_d     = (cmd_i == WRITE) ? eWrite : eRead;
        end
      end

      eRead: begin
        app_if.app_en_o = 1'b1;
        if (app_if.app_rdy_i) begin
          read_hs = 1'b1;
          state_d = eIdle;
        end
      end

      // Command and data run independently; leave once both have finished.
      eWrite: begin
        app_if.app_en_o       = ~cmd_done_q;
        app_if.app_wdf_wren_o = ~data_done_q;
        app_if.app_wdf_end_o  = ~data_done_q & last_beat;
        data_hs     = ~data_done_q & app_if.app_wdf_rdy_i;
        last_hs     = data_hs & last_beat;
        cmd_done_d  = cmd_done_q  | (~cmd_done_q & app_if.app_rdy_i);
        data_done_d = data_done_q | last_hs;
        if (cmd_done_d & data_done_d) state_d = eIdle;
      end

      default: state_d = eIdle;
    endcase

    credit_d = credit_q + credit_w_lp'(read_hs) - credit_w_lp'(yumi_i);
  end

  assign app_if.app_cmd_o      = cmd_q;
  assign app_if.app_addr_o     = addr_q;
  assign app_if.app_wdf_data_o = data_q[wbeat];
  assign app_if.app_wdf_mask_o = mask_q[wbeat];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= eIdle;
      cmd_done_q  <= 1'b0;
      data_done_q <= 1'b0;
      credit_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_done_q  <= cmd_done_d;
      data_done_q <= data_done_d;
      credit_q    <= credit_d;
    end
  end

  always_ff @(posedge clk_i) begin
    cmd_q  <= cmd_d;
    addr_q <= addr_d;
    data_q <= data_d;
    mask_q <= mask_d;
  end

  bsg_counter_clear_up #(
    .max_val_p  (ui_burst_len_p - 1),
    .init_val_p (0)
  ) wbeat_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (last_hs),
    .up_i    (data_hs & ~last_beat),
    .count_o (wbeat)
  );

  bsg_dmc_ui_burst_master_rbuf #(
    .data_width_p (ui_data_width_p),
    .burst_len_p  (ui_burst_len_p),
    .els_p        (rfifo_depth_p)
  ) rbuf (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .beat_v_i    (app_if.app_rd_data_valid_i),
    .beat_data_i (app_if.app_rd_data_i),
    .beat_end_i  (app_if.app_rd_data_end_i),
    .data_o      (data_o),
    .yumi_i      (yumi_i),
    .full_o      (rbuf_full),
    .empty_o     (rbuf_empty),
    .count_o     (rbuf_count)
  );

  assign v_o = ~rbuf_empty;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (credit_q <= credit_w_lp'(rfifo_depth_p));
      assert (credit_q >= rbuf_count);
      assert (!rbuf_full || (credit_q == credit_w_lp'(rfifo_depth_p)));
    end
  end

endmodule

// File: tb/tb_bsg_dmc_ui_burst_master.sv
// Directed bench for the DMC burst master: stimulus pushes expected commands, write beats and read
// bursts into queues; a negedge monitor pops and compares on every DMC or consumer handshake.
module tb_bsg_dmc_ui_burst_master;
  import bsg_dmc_pkg::*;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int BL = 2;
  localparam int DEPTH = 2;
  localparam int MW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, v, ready, v_o, yumi;
  app_cmd_e          cmd;
  logic [AW-1:0]     addr;
  logic [BL*DW-1:0]  data, data_o;
  logic [BL*MW-1:0]  mask;

  bsg_dmc_ui_burst_master_if #(.addr_width_p(AW), .data_width_p(DW)) dmc_if ();

  bsg_dmc_ui_burst_master #(
    .ui_addr_width_p (AW),
    .ui_data_width_p (DW),
    .ui_burst_len_p  (BL),
    .rfifo_depth_p   (DEPTH)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .v_i     (v),
    .cmd_i   (cmd),
    .addr_i  (addr),
    .data_i  (data),
    .mask_i  (mask),
    .ready_o (ready),
    .data_o  (data_o),
    .v_o     (v_o),
    .yumi_i  (yumi),
    .app_if  (dmc_if)
  );

  typedef struct packed { app_cmd_e cmd; logic [AW-1:0] addr; } cmd_t;
  typedef struct packed { logic [DW-1:0] data; logic [MW-1:0] mask; logic last; } beat_t;

  cmd_t             exp_cmd_q[$];
  beat_t            exp_beat_q[$];
  logic [BL*DW-1:0] exp_rd_q[$];

  int errors = 0;
  int checks = 0;

  cmd_t             mon_cmd, got_cmd;
  beat_t            mon_beat, got_beat;
  logic [BL*DW-1:0] mon_rd;

  function automatic logic [DW-1:0] pat(input logic [31:0] t);
    return {t, ~t, t ^ 32'h5A5A_5A5A, t + 32'h1};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (dmc_if.app_en_o && dmc_if.app_rdy_i) begin
        checks++;
        got_cmd = '{cmd: dmc_if.app_cmd_o, addr: dmc_if.app_addr_o};
        if (exp_cmd_q.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected: got cmd=%0d addr=%0h expected none", got_cmd.cmd, got_cmd.addr);
        end else begin
          mon_cmd = exp_cmd_q.pop_front();
          if (got_cmd !== mon_cmd) begin
            errors++;
            $display("FAIL cmd: got cmd=%0d addr=%0h expected cmd=%0d addr=%0h",
                     got_cmd.cmd, got_cmd.addr, mon_cmd.cmd, mon_cmd.addr);
          end
        end
      end
      if (dmc_if.app_wdf_wren_o && dmc_if.app_wdf_rdy_i) begin
        checks++;
        got_beat = '{data: dmc_if.app_wdf_data_o, mask: dmc_if.app_wdf_mask_o, last: dmc_if.app_wdf_end_o};
        if (exp_beat_q.size() == 0) begin
          errors++;
          $display("FAIL wbeat_unexpected: got data=%0h expected none", got_beat.data);
        end else begin
          mon_beat = exp_beat_q.pop_front();
          if (got_beat !== mon_beat) begin
            errors++;
            $display("FAIL wbeat: got data=%0h mask=%0h end=%0b expected data=%0h mask=%0h end=%0b",
                     got_beat.data, got_beat.mask, got_beat.last, mon_beat.data, mon_beat.mask, mon_beat.last);
          end
        end
      end
      if (v_o && yumi) begin
        checks++;
        if (exp_rd_q.size() == 0) begin
          errors++;
          $display("FAIL rdburst_unexpected: got %0h expected none", data_o);
        end else begin
          mon_rd = exp_rd_q.pop_front();
          if (data_o !== mon_rd) begin
            errors++;
            $display("FAIL rdburst: got %0h expected %0h", data_o, mon_rd);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_write(input logic [AW-1:0] a, input logic [BL*DW-1:0] d, input logic [BL*MW-1:0] m);
    exp_cmd_q.push_back('{cmd: WRITE, addr: a});
    exp_beat_q.push_back('{data: d[DW-1:0], mask: m[MW-1:0], last: 1'b0});
    exp_beat_q.push_back('{data: d[2*DW-1:DW], mask: m[2*MW-1:MW], last: 1'b1});
  endtask

  task automatic push_read(input logic [AW-1:0] a);
    exp_cmd_q.push_back('{cmd: READ, addr: a});
  endtask

  // Present a request and hold it until accepted; returns at accept edge + 1.
  task automatic issue(input app_cmd_e c, input logic [AW-1:0] a, input logic [BL*DW-1:0] d,
                       input logic [BL*MW-1:0] m);
    int n;
    n = 0;
    v = 1'b1; cmd = c; addr = a; data = d; mask = m;
    #1;
    while (!ready && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: ready_o=0 expected 1 within 50 cycles (addr %0h)", a);
    end
    @(posedge clk);
    #1;
    v = 1'b0;
  endtask

  task automatic rd_return(input logic [DW-1:0] r0, input logic [DW-1:0] r1);
    exp_rd_q.push_back({r1, r0});
    dmc_if.app_rd_data_valid_i = 1'b1;
    dmc_if.app_rd_data_i = r0;
    dmc_if.app_rd_data_end_i = 1'b0;
    tick();
    dmc_if.app_rd_data_i = r1;
    dmc_if.app_rd_data_end_i = 1'b1;
    tick();
    dmc_if.app_rd_data_valid_i = 1'b0;
    dmc_if.app_rd_data_end_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; v = 1'b0; cmd = WRITE; addr = '0; data = '0; mask = '0; yumi = 1'b0;
    dmc_if.app_rdy_i = 1'b1;
    dmc_if.app_wdf_rdy_i = 1'b1;
    dmc_if.app_rd_data_valid_i = 1'b0;
    dmc_if.app_rd_data_i = '0;
    dmc_if.app_rd_data_end_i = 1'b0;
    repeat (3) tick();

    check("rst_ready", ready, 0);
    check("rst_app_en", dmc_if.app_en_o, 0);
    check("rst_wren", dmc_if.app_wdf_wren_o, 0);
    check("rst_wdf_end", dmc_if.app_wdf_end_o, 0);
    check("rst_v_o", v_o, 0);
    reset = 1'b0;
    #1;
    check("idle_ready", ready, 1);
    tick();

    // 1: plain write, both ports ready
    push_write(28'h40, {pat(32'hB1), pat(32'hB0)}, '0);
    issue(WRITE, 28'h40, {pat(32'hB1), pat(32'hB0)}, '0);
    check("t1_busy_c1", ready, 0);
    tick();
    check("t1_busy_c2", ready, 0);
    tick();
    check("t1_ready_c3", ready, 1);

    // 2: command port stalls while data finishes first
    dmc_if.app_rdy_i = 1'b0;
    push_write(28'h44, {pat(32'hB3), pat(32'hB2)}, 32'h0000_F00F);
    issue(WRITE, 28'h44, {pat(32'hB3), pat(32'hB2)}, 32'h0000_F00F);
    for (int i = 1; i <= 5; i++) begin
      check("t2_en_held", dmc_if.app_en_o, 1);
      if (i >= 3) check("t2_data_done", dmc_if.app_wdf_wren_o, 0);
      tick();
    end
    check("t2_busy", ready, 0);
    dmc_if.app_rdy_i = 1'b1;
    tick();
    check("t2_exit_ready", ready, 1);
    check("t2_exit_en", dmc_if.app_en_o, 0);

    // 3: single read round trip
    push_read(28'h80);
    issue(READ, 28'h80, '0, '0);
    tick();
    rd_return(pat(32'hA0), pat(32'hA1));
    check("t3_v", v_o, 1);
    yumi = 1'b1;
    tick();
    yumi = 1'b0;
    check("t3_popped", v_o, 0);

    // 4: fill the read credit, write still accepted, third read stalls until a pop
    push_read(28'h100);
    issue(READ, 28'h100, '0, '0);
    tick();
    rd_return(pat(32'hC0), pat(32'hC1));
    push_read(28'h140);
    issue(READ, 28'h140, '0, '0);
    tick();
    rd_return(pat(32'hD0), pat(32'hD1));
    v = 1'b1; cmd = WRITE; addr = 28'h180;
    #1;
    check("t4_wr_full_ready", ready, 1);
    push_write(28'h180, {pat(32'hB5), pat(32'hB4)}, 32'h00FF_0001);
    issue(WRITE, 28'h180, {pat(32'hB5), pat(32'hB4)}, 32'h00FF_0001);
    tick();
    tick();
    push_read(28'h1C0);
    v = 1'b1; cmd = READ; addr = 28'h1C0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("t4_rd_stall", ready, 0);
      @(posedge clk);
      #2;
    end

    // 5: pop and read accept in the same cycle at full credit
    yumi = 1'b1;
    #1;
    check("t5_pop_accept_ready", ready, 1);
    @(posedge clk);
    #1;
    v = 1'b0; yumi = 1'b0;
    tick();
    rd_return(pat(32'hE0), pat(32'hE1));
    push_read(28'h200);
    v = 1'b1; cmd = READ; addr = 28'h200;
    #1;
    check("t5_credit_still_full", ready, 0);
    @(posedge clk);
    #2;
    yumi = 1'b1;
    #1;
    check("t5_pop_accept_ready2", ready, 1);
    @(posedge clk);
    #1;
    v = 1'b0; yumi = 1'b0;
    tick();
    rd_return(pat(32'hF0), pat(32'hF1));

    // 6: reset in the middle of a write
    check("t6_v_before", v_o, 1);
    dmc_if.app_rdy_i = 1'b0;
    push_write(28'h240, {pat(32'hB7), pat(32'hB6)}, '0);
    issue(WRITE, 28'h240, {pat(32'hB7), pat(32'hB6)}, '0);
    tick();
    reset = 1'b1;
    tick();
    check("t6_app_en", dmc_if.app_en_o, 0);
    check("t6_wren", dmc_if.app_wdf_wren_o, 0);
    check("t6_wdf_end", dmc_if.app_wdf_end_o, 0);
    check("t6_v_o", v_o, 0);
    exp_cmd_q.delete();
    exp_beat_q.delete();
    exp_rd_q.delete();
    reset = 1'b0;
    dmc_if.app_rdy_i = 1'b1;
    #1;
    check("t6_ready_after", ready, 1);
    tick();
    push_write(28'h280, {pat(32'hB9), pat(32'hB8)}, 32'hFFFF_0000);
    issue(WRITE, 28'h280, {pat(32'hB9), pat(32'hB8)}, 32'hFFFF_0000);
    tick();
    tick();
    check("t6_post_write_done", ready, 1);
    push_read(28'h2C0);
    issue(READ, 28'h2C0, '0, '0);
    tick();
    rd_return(pat(32'h90), pat(32'h91));
    check("t6_post_read_v", v_o, 1);
    yumi = 1'b1;
    tick();
    yumi = 1'b0;
    check("t6_post_read_popped", v_o, 0);

    repeat (3) tick();
    check("end_cmd_q_empty", exp_cmd_q.size(), 0);
    check("end_beat_q_empty", exp_beat_q.size(), 0);
    check("end_rd_q_empty", exp_rd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
